// File: rtl/bullet_pool.sv
// bullet_pool: multi-slot player projectile manager.
// Fires on the rising edge of the fire key into the lowest-index free slot.
// A frame cooldown limits the fire rate. Each live bullet climbs by Y_STEP
// once per frame until it is hit or passes the top boundary.
//
// Handshake note: there is no valid/ready handshake on this block. The key
// edge acts as a single-cycle request. A request that cannot be served at the
// same edge is dropped, not queued. 'fired' is the one-frame acknowledge.
module bullet_pool #(
   parameter int unsigned NUM_BULLETS = 4,
   parameter logic [7:0]  KEY_FIRE    = 8'h2C,
   parameter logic [9:0]  Y_START     = 10'd400,
   parameter logic [9:0]  Y_STEP      = 10'd4,
   parameter logic [9:0]  Y_MIN       = 10'd8,
   parameter logic [9:0]  X_OFFSET    = 10'd0,
   parameter logic [3:0]  COOLDOWN    = 4'd3
) (
   input  logic                        frame_clk,
   input  logic                        Reset,
   input  logic [7:0]                  keycode,
   input  logic [9:0]                  player_X,
   input  logic [NUM_BULLETS-1:0]      hit,
   output logic [10*NUM_BULLETS-1:0]   bullet_X,
   output logic [10*NUM_BULLETS-1:0]   bullet_Y,
   output logic [NUM_BULLETS-1:0]      bullet_active,
   output logic                        fired,
   output logic [3:0]                  free_count
);

   // The exit threshold is an unsigned sum computed one bit wider. A bullet
   // whose Y is below it would underflow or cross the top on its next move,
   // so it is retired instead of moved.
   localparam logic [10:0] EXIT_LIM = {1'b0, Y_MIN} + {1'b0, Y_STEP};

   // Registered state
   logic [NUM_BULLETS-1:0] active_q, active_d;
   logic [9:0]             x_q [NUM_BULLETS];
   logic [9:0]             x_d [NUM_BULLETS];
   logic [9:0]             y_q [NUM_BULLETS];
   logic [9:0]             y_d [NUM_BULLETS];
   logic [3:0]             cd_q, cd_d;
   logic                   key_prev_q, key_prev_d;
   logic                   fired_q, fired_d;

   // Decode and allocation helpers
   logic                   key_now;
   logic                   fire_req;
   logic                   any_free;
   logic                   accept;
   logic [NUM_BULLETS-1:0] alloc_oh;
   logic [9:0]             launch_x;

   // Fire-key edge detection and launch-column computation
   always_comb begin
      key_now  = (keycode == KEY_FIRE);
      fire_req = key_now && !key_prev_q;
      launch_x = player_X + X_OFFSET;
   end

   // Pick the lowest-index slot that is free in the registered vector.
   // Slots freed at this same edge are deliberately not considered.
   always_comb begin
      alloc_oh = '0;
      any_free = 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (!active_q[i] && !any_free) begin
            alloc_oh[i] = 1'b1;
            any_free    = 1'b1;
         end
      end
   end

   // Shot acceptance, cooldown and the fired pulse
   always_comb begin
      accept     = fire_req && (cd_q == 4'd0) && any_free;
      key_prev_d = key_now;
      fired_d    = accept;
      cd_d       = cd_q;
      if (accept) begin
         cd_d = COOLDOWN;
      end else if (cd_q != 4'd0) begin
         cd_d = cd_q - 4'd1;
      end
   end

   // Per-slot next state: a launch takes priority, then hit, then top exit,
   // then the upward move. A freshly launched slot does not move this edge.
   always_comb begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
         active_d[i] = active_q[i];
         x_d[i]      = x_q[i];
         y_d[i]      = y_q[i];
         if (accept && alloc_oh[i]) begin
            active_d[i] = 1'b1;
            x_d[i]      = launch_x;
            y_d[i]      = Y_START;
         end else if (active_q[i]) begin
            if (hit[i]) begin
               active_d[i] = 1'b0;
            end else if ({1'b0, y_q[i]} < EXIT_LIM) begin
               active_d[i] = 1'b0;
            end else begin
               y_d[i] = y_q[i] - Y_STEP;
            end
         end
      end
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         active_q   <= '0;
         cd_q       <= 4'd0;
         key_prev_q <= 1'b0;
         fired_q    <= 1'b0;
         for (int i = 0; i < NUM_BULLETS; i++) begin
            x_q[i] <= 10'd0;
            y_q[i] <= Y_START;
         end
      end else begin
         active_q   <= active_d;
         cd_q       <= cd_d;
         key_prev_q <= key_prev_d;
         fired_q    <= fired_d;
         for (int i = 0; i < NUM_BULLETS; i++) begin
            x_q[i] <= x_d[i];
            y_q[i] <= y_d[i];
         end
      end
   end

   // Pack slot coordinates onto the flat buses and count free slots
   always_comb begin
      bullet_X   = '0;
      bullet_Y   = '0;
      free_count = 4'd0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         bullet_X[10*i +: 10] = x_q[i];
         bullet_Y[10*i +: 10] = y_q[i];
         if (!active_q[i]) begin
            free_count = free_count + 4'd1;
         end
      end
   end

   assign bullet_active = active_q;
   assign fired         = fired_q;

endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: scoreboard bench for bullet_pool with default parameters.
// Inputs change 1 time unit after the rising edge. Outputs are sampled at
// that same point, so each sample reflects the edge just taken.
module tb_bullet_pool;

   localparam int         NB  = 4;
   localparam logic [7:0] KEY = 8'h2C;

   // Clock and reset
   logic                frame_clk = 1'b0;
   logic                Reset;
   logic [7:0]          keycode;
   logic [9:0]          player_X;
   logic [NB-1:0]       hit;
   logic [10*NB-1:0]    bullet_X;
   logic [10*NB-1:0]    bullet_Y;
   logic [NB-1:0]       bullet_active;
   logic                fired;
   logic [3:0]          free_count;

   always #5 frame_clk = ~frame_clk;

   bullet_pool dut (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .keycode       (keycode),
      .player_X      (player_X),
      .hit           (hit),
      .bullet_X      (bullet_X),
      .bullet_Y      (bullet_Y),
      .bullet_active (bullet_active),
      .fired         (fired),
      .free_count    (free_count)
   );

   // Scoreboard
   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic sb_check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check(tag, obs, e);
      end
   endtask

   function automatic logic [9:0] xs(input int i);
      return bullet_X[10*i +: 10];
   endfunction

   function automatic logic [9:0] ys(input int i);
      return bullet_Y[10*i +: 10];
   endfunction

   // Driver tasks
   task automatic frame(input logic key, input logic [9:0] px, input logic [NB-1:0] h);
      keycode  = key ? KEY : 8'h00;
      player_X = px;
      hit      = h;
      @(posedge frame_clk);
      #1;
   endtask

   task automatic do_reset();
      keycode = 8'h00;
      hit     = '0;
      Reset   = 1'b1;
      #3;
      Reset   = 1'b0;
   endtask

   int nf;

   initial begin
      Reset    = 1'b1;
      keycode  = 8'h00;
      player_X = 10'd0;
      hit      = '0;
      @(posedge frame_clk);
      #1;

      // Reset values
      sb_push(0);   sb_check("rst_active", bullet_active);
      sb_push(0);   sb_check("rst_fired", fired);
      sb_push(4);   sb_check("rst_free", free_count);
      for (int i = 0; i < NB; i++) begin
         sb_push(400); sb_check($sformatf("rst_y%0d", i), ys(i));
         sb_push(0);   sb_check($sformatf("rst_x%0d", i), xs(i));
      end
      Reset = 1'b0;

      // Single shot and full lifetime
      frame(1, 10'd100, '0);
      sb_push(1);   sb_check("s1_fired_e0", fired);
      sb_push(1);   sb_check("s1_active_e0", bullet_active);
      sb_push(100); sb_check("s1_x0_e0", xs(0));
      sb_push(400); sb_check("s1_y0_e0", ys(0));
      frame(0, 10'd500, '0);
      sb_push(396); sb_check("s1_y0_e1", ys(0));
      sb_push(100); sb_check("s1_x0_hold", xs(0));
      nf = int'(fired);
      for (int e = 2; e <= 98; e++) begin
         frame(0, 10'd500, '0);
         nf += int'(fired);
      end
      sb_push(8);   sb_check("s1_y0_e98", ys(0));
      sb_push(1);   sb_check("s1_active_e98", bullet_active);
      frame(0, 10'd500, '0);
      nf += int'(fired);
      sb_push(0);   sb_check("s1_active_e99", bullet_active);
      sb_push(8);   sb_check("s1_y0_held", ys(0));
      sb_push(4);   sb_check("s1_free_e99", free_count);
      sb_push(0);   sb_check("s1_fired_later", 32'(nf));

      // Key held for 20 frames
      do_reset();
      nf = 0;
      for (int e = 0; e < 20; e++) begin
         frame(1, 10'd200, '0);
         nf += int'(fired);
      end
      sb_push(1);   sb_check("s2_shots", 32'(nf));
      sb_push(3);   sb_check("s2_free", free_count);
      sb_push(1);   sb_check("s2_active", bullet_active);

      // Toggled key: fire edges on every even frame
      do_reset();
      for (int e = 0; e < 12; e++) begin
         frame((e % 2) == 0, 10'(10*e + 3), '0);
         sb_push(((e % 4) == 0) ? 1 : 0);
         sb_check($sformatf("s3_fired_e%0d", e), fired);
      end
      sb_push(4'b0111); sb_check("s3_active", bullet_active);
      sb_push(3);   sb_check("s3_x0", xs(0));
      sb_push(43);  sb_check("s3_x1", xs(1));
      sb_push(83);  sb_check("s3_x2", xs(2));
      sb_push(356); sb_check("s3_y0", ys(0));
      sb_push(372); sb_check("s3_y1", ys(1));
      sb_push(388); sb_check("s3_y2", ys(2));

      // Fill the pool, reject when full, free-then-allocate ordering
      do_reset();
      for (int e = 0; e < 16; e++) begin
         frame((e % 4) == 0, 10'(5*e), '0);
      end
      sb_push(4'hF); sb_check("s4_full", bullet_active);
      sb_push(0);    sb_check("s4_free0", free_count);
      frame(1, 10'd11, '0);                       // edge 16
      sb_push(0);    sb_check("s4_reject_fired", fired);
      sb_push(4'hF); sb_check("s4_reject_active", bullet_active);
      frame(0, 10'd11, 4'b0001);                  // edge 17
      sb_push(4'b1110); sb_check("s4_hit0", bullet_active);
      sb_push(1);    sb_check("s4_free1", free_count);
      frame(1, 10'd77, '0);                       // edge 18: cooldown stayed 0
      sb_push(1);    sb_check("s4_refire_fired", fired);
      sb_push(4'hF); sb_check("s4_refire_active", bullet_active);
      sb_push(77);   sb_check("s4_refire_x0", xs(0));
      for (int e = 19; e <= 21; e++) frame(0, 10'd0, '0);
      frame(1, 10'd50, 4'b0100);                  // edge 22: hit and fire together
      sb_push(0);    sb_check("s4_same_edge_fired", fired);
      sb_push(4'b1011); sb_check("s4_same_edge_active", bullet_active);
      sb_push(348);  sb_check("s4_y2_frozen", ys(2));
      frame(0, 10'd50, '0);                       // edge 23
      frame(1, 10'd123, '0);                      // edge 24
      sb_push(1);    sb_check("s4_alloc2_fired", fired);
      sb_push(4'hF); sb_check("s4_alloc2_active", bullet_active);
      sb_push(123);  sb_check("s4_alloc2_x", xs(2));
      sb_push(400);  sb_check("s4_alloc2_y", ys(2));

      // Hit on slot 1, and hit on an inactive slot ignored
      do_reset();
      frame(1, 10'd30, '0);
      for (int e = 1; e <= 3; e++) frame(0, 10'd30, '0);
      frame(1, 10'd60, '0);                       // edge 4
      frame(0, 10'd60, '0);                       // edge 5
      frame(0, 10'd90, 4'b0010);                  // edge 6
      sb_push(4'b0001); sb_check("s5_active_e6", bullet_active);
      sb_push(396);  sb_check("s5_y1_e6", ys(1));
      sb_push(60);   sb_check("s5_x1_e6", xs(1));
      sb_push(376);  sb_check("s5_y0_e6", ys(0));
      frame(0, 10'd90, 4'b1000);                  // edge 7
      sb_push(4'b0001); sb_check("s5_active_e7", bullet_active);
      sb_push(396);  sb_check("s5_y1_e7", ys(1));
      sb_push(372);  sb_check("s5_y0_e7", ys(0));
      sb_push(3);    sb_check("s5_free_e7", free_count);

      // Reset mid-flight with the key held
      do_reset();
      frame(1, 10'd10, '0);
      for (int e = 1; e <= 3; e++) frame(0, 10'd10, '0);
      frame(1, 10'd20, '0);
      for (int e = 5; e <= 7; e++) frame(0, 10'd20, '0);
      frame(1, 10'd30, '0);                       // edge 8, key stays held
      sb_push(1);       sb_check("s6_fired_e8", fired);
      sb_push(4'b0111); sb_check("s6_active_e8", bullet_active);
      #2;
      Reset = 1'b1;
      #1;
      sb_push(0);    sb_check("s6_rst_active", bullet_active);
      sb_push(0);    sb_check("s6_rst_fired", fired);
      sb_push(4);    sb_check("s6_rst_free", free_count);
      for (int i = 0; i < NB; i++) begin
         sb_push(400); sb_check($sformatf("s6_rst_y%0d", i), ys(i));
         sb_push(0);   sb_check($sformatf("s6_rst_x%0d", i), xs(i));
      end
      #1;
      Reset = 1'b0;
      frame(1, 10'd222, '0);
      sb_push(1);    sb_check("s6_post_fired", fired);
      sb_push(1);    sb_check("s6_post_active", bullet_active);
      sb_push(222);  sb_check("s6_post_x0", xs(0));

      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
